// File: rtl/hold_n_pkg.sv
// Shared types and helpers for the hold_n channel-rotating hold generator.
package hold_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  // Ceiling log2, used at elaboration to tie the channel index width to NCH.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hold_n_cnt.sv
// Loadable down counter that saturates at zero; zero flags the end of a hold.
module hold_n_cnt
#(
  parameter int CW = 8
)
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  // Count register: a load wins over a decrement, and zero is sticky until reloaded.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hold_n.sv
// Sequences NCH one-hot hold outputs with a one-cycle all-low gap between
// channels; f marks completion (one-shot) or wrap-around (continuous).
module hold_n
  import hold_n_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 8,
  parameter int CHW = 2
)
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stop,
  input  logic           mode,
  input  logic [CW-1:0]  hold_len,
  output logic [NCH-1:0] g,
  output logic           f,
  output logic           busy,
  output logic [CHW-1:0] ch
);

  if (CHW != clog2(NCH)) begin : g_bad_chw
    $error("hold_n: CHW must equal clog2(NCH)");
  end
  if ((NCH < 2) || (NCH > 16)) begin : g_bad_nch
    $error("hold_n: NCH must lie in 2..16");
  end

  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

  state_e          state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [CW-1:0]   len_q, len_d;
  logic            mode_q, mode_d;
  logic [NCH-1:0]  g_q, g_d;
  logic            f_q, f_d;
  logic            busy_q, busy_d;

  logic [CW-1:0]   start_len;
  logic            cnt_load;
  logic [CW-1:0]   cnt_load_val;
  logic            cnt_dec;
  logic            cnt_zero;

  hold_n_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // A zero hold length behaves as one cycle.
  always_comb begin
    start_len = (hold_len == '0) ? CW'(1) : hold_len;
  end

  // Next-state logic: stop beats everything, start is honoured only when idle or done.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    len_d        = len_q;
    mode_d       = mode_q;
    cnt_load     = 1'b0;
    cnt_load_val = len_q - CW'(1);
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (stop) begin
          state_d = IDLE;
          ch_d    = '0;
        end else if (start) begin
          len_d        = start_len;
          mode_d       = mode;
          ch_d         = '0;
          cnt_load     = 1'b1;
          cnt_load_val = start_len - CW'(1);
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          ch_d    = '0;
        end else if (cnt_zero) begin
          state_d = GAP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
          ch_d    = '0;
        end else if (ch_q != LAST_CH) begin
          ch_d     = ch_q + CHW'(1);
          cnt_load = 1'b1;
          state_d  = HOLD;
        end else if (mode_q == MODE_CONT) begin
          ch_d     = '0;
          cnt_load = 1'b1;
          state_d  = HOLD;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = '0;
      end
    endcase
  end

  // Moore outputs decoded from the next state so they appear registered with it.
  always_comb begin
    g_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if ((state_d == HOLD) && (ch_d == CHW'(i))) begin
        g_d[i] = 1'b1;
      end
    end
    busy_d = (state_d == HOLD) || (state_d == GAP);
    f_d    = (state_d == DONE) ||
             ((state_d == GAP) && (ch_d == LAST_CH) && (mode_d == MODE_CONT));
  end

  // State, latched configuration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      len_q   <= '0;
      mode_q  <= MODE_ONESHOT;
      g_q     <= '0;
      f_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      g_q     <= g_d;
      f_q     <= f_d;
      busy_q  <= busy_d;
    end
  end

  assign g    = g_q;
  assign f    = f_q;
  assign busy = busy_q;
  assign ch   = ch_q;

endmodule

// File: tb/tb_hold_n.sv
// Bench for hold_n (NCH=4, CW=8): a vector table plus model-driven sequences,
// with expected outputs queued at drive time and compared after each edge.
module tb_hold_n;

  typedef struct packed {
    logic [3:0] g;
    logic       f;
    logic       busy;
    logic [1:0] ch;
  } out_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] len;
    out_t       exp;
  } vec_t;

  localparam out_t IDLE_OUT = '0;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] hold_len;
  logic [3:0] g;
  logic       f;
  logic       busy;
  logic [1:0] ch;

  int n_pass;
  int n_total;

  out_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[18];

  hold_n #(.NCH(4), .CW(8), .CHW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .hold_len (hold_len),
    .g        (g),
    .f        (f),
    .busy     (busy),
    .ch       (ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t cur();
    return {g, f, busy, ch};
  endfunction

  function automatic out_t mk_out(input logic [3:0] eg, input logic ef,
                                  input logic eb, input logic [1:0] ec);
    return {eg, ef, eb, ec};
  endfunction

  function automatic vec_t mk_vec(input logic s, input logic p, input logic m,
                                  input logic [7:0] l, input out_t e);
    return {s, p, m, l, e};
  endfunction

  // Expected outputs in cycle k after a start at edge 0 (cycle k follows edge k-1).
  function automatic out_t exp_at(input int k, input int len, input bit cont);
    int   le;
    int   p;
    int   seq;
    int   kk;
    int   c;
    int   ph;
    out_t e;
    le  = (len == 0) ? 1 : len;
    p   = le + 1;
    seq = 4 * p;
    e   = '0;
    if (!cont && (k > seq)) begin
      e.f  = 1'b1;
      e.ch = 2'd3;
      return e;
    end
    kk     = cont ? ((k - 1) % seq) : (k - 1);
    c      = kk / p;
    ph     = kk % p;
    e.ch   = 2'(c);
    e.busy = 1'b1;
    if (ph < le) e.g = 4'(1 << c);
    else         e.f = cont && (c == 3);
    return e;
  endfunction

  task automatic check(input string nm, input out_t act, input out_t exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got g=%b f=%b busy=%b ch=%0d, expected g=%b f=%b busy=%b ch=%0d",
               nm, act.g, act.f, act.busy, act.ch, exp.g, exp.f, exp.busy, exp.ch);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one set of inputs, queue the expectation, compare after the edge.
  task automatic step(input logic s, input logic p, input logic m,
                      input logic [7:0] l, input out_t e, input string nm);
    out_t  want;
    string wn;
    @(negedge clk);
    start    = s;
    stop     = p;
    mode     = m;
    hold_len = l;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    wn   = name_q.pop_front();
    check(wn, cur(), want);
  endtask

  // Start a sequence, optionally pulse start while busy (with altered len/mode)
  // and optionally abort with stop; every cycle is compared to the model.
  task automatic run_seq(input int len, input bit cont, input int n,
                         input int abort_at, input int pa, input int pb,
                         input string nm);
    for (int k = 1; k <= n; k++) begin
      logic       s;
      logic       p;
      logic       m;
      logic [7:0] l;
      out_t       e;
      s = (k == 1) || (k == pa) || (k == pb);
      p = (k == abort_at);
      m = (k == 1) ? cont : !cont;
      l = (k == 1) ? 8'(len) : 8'(len) + 8'd5;
      e = ((abort_at > 0) && (k >= abort_at)) ? IDLE_OUT : exp_at(k, len, cont);
      step(s, p, m, l, e, $sformatf("%s[%0d]", nm, k));
    end
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst_n    = 1'b0;
    start    = 1'b1;
    stop     = 1'b0;
    mode     = 1'b0;
    hold_len = 8'd3;

    vecs[0]  = mk_vec(0, 0, 0, 8'd0, mk_out(4'b0000, 0, 0, 2'd0));
    vecs[1]  = mk_vec(1, 1, 0, 8'd3, mk_out(4'b0000, 0, 0, 2'd0));
    vecs[2]  = mk_vec(1, 0, 0, 8'd0, mk_out(4'b0001, 0, 1, 2'd0));
    vecs[3]  = mk_vec(0, 0, 0, 8'd0, mk_out(4'b0000, 0, 1, 2'd0));
    vecs[4]  = mk_vec(1, 0, 1, 8'd5, mk_out(4'b0010, 0, 1, 2'd1));
    vecs[5]  = mk_vec(0, 0, 0, 8'd0, mk_out(4'b0000, 0, 1, 2'd1));
    vecs[6]  = mk_vec(0, 0, 0, 8'd0, mk_out(4'b0100, 0, 1, 2'd2));
    vecs[7]  = mk_vec(0, 1, 0, 8'd0, mk_out(4'b0000, 0, 0, 2'd0));
    vecs[8]  = mk_vec(1, 0, 1, 8'd1, mk_out(4'b0001, 0, 1, 2'd0));
    vecs[9]  = mk_vec(0, 0, 0, 8'd9, mk_out(4'b0000, 0, 1, 2'd0));
    vecs[10] = mk_vec(0, 0, 0, 8'd9, mk_out(4'b0010, 0, 1, 2'd1));
    vecs[11] = mk_vec(0, 0, 0, 8'd9, mk_out(4'b0000, 0, 1, 2'd1));
    vecs[12] = mk_vec(0, 0, 0, 8'd9, mk_out(4'b0100, 0, 1, 2'd2));
    vecs[13] = mk_vec(0, 0, 0, 8'd9, mk_out(4'b0000, 0, 1, 2'd2));
    vecs[14] = mk_vec(0, 0, 0, 8'd9, mk_out(4'b1000, 0, 1, 2'd3));
    vecs[15] = mk_vec(0, 0, 0, 8'd9, mk_out(4'b0000, 1, 1, 2'd3));
    vecs[16] = mk_vec(0, 0, 0, 8'd9, mk_out(4'b0001, 0, 1, 2'd0));
    vecs[17] = mk_vec(0, 1, 0, 8'd9, mk_out(4'b0000, 0, 0, 2'd0));

    // Reset held with start high: outputs stay cleared across edges.
    #1;
    check("rst_t1", cur(), IDLE_OUT);
    @(posedge clk);
    #1;
    check("rst_edge1", cur(), IDLE_OUT);
    @(posedge clk);
    #1;
    check("rst_edge2", cur(), IDLE_OUT);
    @(negedge clk);
    start = 1'b0;
    #2;
    rst_n = 1'b1;

    // Vector table: start/stop priority, len 0, ignored start, abort, wrap pulse.
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].len, vecs[i].exp,
           $sformatf("vec%0d", i));
    end

    // One-shot len 3 with start pulses while busy; f held in DONE.
    run_seq(3, 1'b0, 24, 0, 3, 8, "oneshot3");
    // Restart from DONE with len 1: f drops with g[0] rising.
    run_seq(1, 1'b0, 10, 0, 0, 0, "done_restart");
    // Continuous len 2: period 12, wrap pulse every 12th cycle.
    run_seq(2, 1'b1, 40, 0, 0, 0, "cont2");
    step(1'b0, 1'b1, 1'b0, 8'd0, IDLE_OUT, "cont_stop");
    // Zero length behaves as one.
    run_seq(0, 1'b0, 10, 0, 0, 0, "len0");
    // Maximum length, no counter wrap.
    run_seq(255, 1'b0, 4 * 256 + 3, 0, 0, 0, "len255");
    // Abort mid-sequence.
    run_seq(3, 1'b0, 10, 7, 0, 0, "abort");

    // Asynchronous reset in HOLD clears outputs before the next edge.
    run_seq(3, 1'b0, 2, 0, 0, 0, "pre_async");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst", cur(), IDLE_OUT);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'd3, IDLE_OUT, "post_rst_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
